// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the instruction decoder, jump LUT and pc_sequencer.
// The decoder/LUT side holds the master modport; the sequencer holds the slave.
interface pc_sequencer_if #(
    parameter int PC_W  = 12,
    parameter int IDX_W = 5
);
    logic             Start;
    logic [1:0]       Prog_sel;
    logic             Stall;
    logic             Halt;
    logic             Branch_taken;
    logic [IDX_W-1:0] Branch_idx;
    logic [PC_W-1:0]  Jump;
    logic [IDX_W-1:0] Lut_addr;
    logic [PC_W-1:0]  Prog_ctr;
    logic             Busy;
    logic             Done;
    logic             Overrun;

    modport master (
        output Start, Prog_sel, Stall, Halt, Branch_taken, Branch_idx, Jump,
        input  Lut_addr, Prog_ctr, Busy, Done, Overrun
    );

    modport slave (
        input  Start, Prog_sel, Stall, Halt, Branch_taken, Branch_idx, Jump,
        output Lut_addr, Prog_ctr, Busy, Done, Overrun
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: launches a program at a selectable base, steps the PC,
// takes branches through a registered jump-LUT address, and ends on halt or overrun.
module pc_sequencer #(
    parameter int          PC_W     = 12,
    parameter int          IDX_W    = 5,
    parameter int unsigned BASE0    = 0,
    parameter int unsigned BASE1    = 0,
    parameter int unsigned BASE2    = 0,
    parameter int unsigned PC_LIMIT = 4095
) (
    input  logic         Clk,
    input  logic         Reset,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_BRANCH = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]       state;
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] lut_addr;
    logic             overrun;
    logic [PC_W-1:0]  start_pc;

    // Prog_sel 3 is not a real program and falls back to program 0.
    always_comb begin
        start_pc = PC_W'(BASE0);
        case (bus.Prog_sel)
            2'd1:    start_pc = PC_W'(BASE1);
            2'd2:    start_pc = PC_W'(BASE2);
            default: start_pc = PC_W'(BASE0);
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            lut_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        pc      <= start_pc;
                        overrun <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.Stall) begin
                        if (bus.Halt) begin
                            state <= S_FINISH;
                        end else if (bus.Branch_taken) begin
                            lut_addr <= bus.Branch_idx;
                            state    <= S_BRANCH;
                        end else if (pc == PC_W'(PC_LIMIT)) begin
                            overrun <= 1'b1;
                            state   <= S_FINISH;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                // Jump is valid here because lut_addr was registered last cycle.
                S_BRANCH: begin
                    if (!bus.Stall) begin
                        pc    <= bus.Jump;
                        state <= S_RUN;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.Prog_ctr = pc;
    assign bus.Lut_addr = lut_addr;
    assign bus.Overrun  = overrun;
    assign bus.Busy     = (state == S_RUN) || (state == S_BRANCH);
    assign bus.Done     = (state == S_FINISH);
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked every
// cycle against a behavioural model of the fetch sequence.
module tb_pc_sequencer;
    localparam int LIM = 60;
    localparam int B0  = 18;
    localparam int B1  = 32;
    localparam int B2  = 52;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    pc_sequencer_if #(.PC_W(12), .IDX_W(5)) bus ();

    pc_sequencer #(
        .PC_W(12), .IDX_W(5), .BASE0(B0), .BASE1(B1), .BASE2(B2), .PC_LIMIT(LIM)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    logic [11:0] lut [32];
    assign bus.Jump = lut[bus.Lut_addr];

    int vectors = 0;
    int miscompares = 0;

    // Model: phase of the program (idle/running/bubble/ending) plus architectural values.
    typedef enum int {M_IDLE, M_RUN, M_BUBBLE, M_END} mphase_t;
    mphase_t     m_ph;
    int          m_pc;
    int          m_lut;
    bit          m_ovr;

    function automatic int base_of(input int sel);
        return (sel == 1) ? B1 : (sel == 2) ? B2 : B0;
    endfunction

    task automatic model_step(input bit r, input bit s, input int sel,
                              input bit st, input bit h, input bit b, input int idx);
        if (r) begin
            m_ph = M_IDLE; m_pc = 0; m_lut = 0; m_ovr = 0;
        end else if (m_ph == M_IDLE) begin
            if (s) begin m_pc = base_of(sel); m_ovr = 0; m_ph = M_RUN; end
        end else if (m_ph == M_RUN) begin
            if (st) ;
            else if (h) m_ph = M_END;
            else if (b) begin m_lut = idx; m_ph = M_BUBBLE; end
            else if (m_pc == LIM) begin m_ovr = 1; m_ph = M_END; end
            else m_pc = (m_pc + 1) % 4096;
        end else if (m_ph == M_BUBBLE) begin
            if (!st) begin m_pc = int'(lut[m_lut]); m_ph = M_RUN; end
        end else begin
            m_ph = M_IDLE;
        end
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = (m_ph == M_RUN) || (m_ph == M_BUBBLE);
        vectors++;
        if (int'(bus.Prog_ctr) != m_pc) begin
            miscompares++; $display("FAIL prog_ctr got %0d want %0d at %0t", bus.Prog_ctr, m_pc, $time);
        end
        if (int'(bus.Lut_addr) != m_lut) begin
            miscompares++; $display("FAIL lut_addr got %0d want %0d at %0t", bus.Lut_addr, m_lut, $time);
        end
        if (bus.Busy !== exp_busy) begin
            miscompares++; $display("FAIL busy got %b want %b at %0t", bus.Busy, exp_busy, $time);
        end
        if (bus.Done !== (m_ph == M_END)) begin
            miscompares++; $display("FAIL done got %b want %b at %0t", bus.Done, m_ph == M_END, $time);
        end
        if (bus.Overrun !== m_ovr) begin
            miscompares++; $display("FAIL overrun got %b want %b at %0t", bus.Overrun, m_ovr, $time);
        end
    endtask

    task automatic lit(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++; $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, compare at the next negedge.
    task automatic cyc(input bit r, input bit s, input int sel,
                       input bit st, input bit h, input bit b, input int idx);
        Reset = r; bus.Start = s; bus.Prog_sel = 2'(sel); bus.Stall = st;
        bus.Halt = h; bus.Branch_taken = b; bus.Branch_idx = 5'(idx);
        model_step(r, s, sel, st, h, b, idx);
        @(negedge Clk);
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 200 && m_pc != target; i++) idle_cyc();
        vectors++;
        if (m_pc != target) begin
            miscompares++; $display("FAIL run_to timeout got %0d want %0d", m_pc, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lut[i] = 12'($urandom_range(0, LIM));
        lut[9] = 12'd32; lut[5] = 12'd7; lut[6] = 12'd44;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 1, 3);
        lit("rst_pc", int'(bus.Prog_ctr), 0);
        lit("rst_busy", int'(bus.Busy), 0);
        lit("rst_done", int'(bus.Done), 0);
        lit("rst_ovr", int'(bus.Overrun), 0);

        // Halt/branch/stall ignored in IDLE
        cyc(0, 0, 0, 1, 1, 1, 4);
        lit("idle_lut", int'(bus.Lut_addr), 0);

        // Launch program 1
        cyc(0, 1, 1, 0, 0, 0, 0);
        lit("start_pc", int'(bus.Prog_ctr), 32);
        lit("start_busy", int'(bus.Busy), 1);
        idle_cyc(); lit("pc33", int'(bus.Prog_ctr), 33);
        idle_cyc(); lit("pc34", int'(bus.Prog_ctr), 34);

        // Taken branch at 40 through LUT entry 9 (target 32)
        run_to(40);
        cyc(0, 0, 0, 0, 0, 1, 9);
        lit("br_lut", int'(bus.Lut_addr), 9);
        lit("br_pc_hold", int'(bus.Prog_ctr), 40);
        idle_cyc(); lit("br_target", int'(bus.Prog_ctr), 32);
        idle_cyc(); lit("br_next", int'(bus.Prog_ctr), 33);

        // Halt beats branch at 50
        run_to(50);
        cyc(0, 1, 2, 0, 1, 1, 3);
        lit("halt_done", int'(bus.Done), 1);
        lit("halt_pc", int'(bus.Prog_ctr), 50);
        lit("halt_lut", int'(bus.Lut_addr), 9);
        idle_cyc();
        lit("halt_done_low", int'(bus.Done), 0);
        lit("halt_idle", int'(bus.Busy), 0);

        // Overrun from program 2 (52 .. 60)
        cyc(0, 1, 2, 0, 0, 0, 0);
        run_to(LIM);
        idle_cyc();
        lit("ovr_flag", int'(bus.Overrun), 1);
        lit("ovr_done", int'(bus.Done), 1);
        lit("ovr_pc", int'(bus.Prog_ctr), LIM);
        // Start held across FINISH->IDLE relaunches and clears Overrun
        cyc(0, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0);
        lit("relaunch_pc", int'(bus.Prog_ctr), B0);
        lit("relaunch_ovr", int'(bus.Overrun), 0);

        // Stall in RUN at PC 7, then stall in BRANCH
        cyc(0, 0, 0, 0, 0, 1, 5);
        idle_cyc();
        lit("pc7", int'(bus.Prog_ctr), 7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            lit("stall_run", int'(bus.Prog_ctr), 7);
        end
        idle_cyc(); lit("stall_resume", int'(bus.Prog_ctr), 8);
        cyc(0, 0, 0, 0, 0, 1, 6);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            lit("stall_br", int'(bus.Prog_ctr), 8);
        end
        idle_cyc(); lit("stall_br_load", int'(bus.Prog_ctr), 44);

        // Reset while in BRANCH, then normal start
        cyc(0, 0, 0, 0, 0, 1, 9);
        cyc(1, 0, 0, 0, 0, 0, 0);
        lit("rstbr_pc", int'(bus.Prog_ctr), 0);
        lit("rstbr_lut", int'(bus.Lut_addr), 0);
        lit("rstbr_busy", int'(bus.Busy), 0);
        cyc(0, 1, 2, 0, 0, 0, 0);
        lit("rstbr_start", int'(bus.Prog_ctr), B2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
